// File: rtl/assoc_cache_ctrl.sv
//==============================================================================
// Module      : assoc_cache_ctrl
// Description : N-way set-associative read cache controller with one-word
//               lines, true-LRU replacement, whole-cache flush, a valid/ready
//               miss-fill handshake to backing memory and saturating hit/miss
//               statistics counters. Tag, data, valid and age storage are
//               register arrays held inside this block.
//
// Ports       : clk, rst          - clock, synchronous active-high reset
//               req_valid/ready   - read request handshake, req_addr = word addr
//                                   (index = low INDEX_W bits, tag = the rest)
//               resp_valid        - one-cycle response strobe with resp_data
//                                   and resp_hit (1 = served from the cache)
//               flush             - invalidate every line (honoured in IDLE)
//               mem_req_*         - fill request to backing memory
//               mem_resp_*        - fill data returning from backing memory
//               hit_count         - saturating hit counter
//               miss_count        - saturating miss counter
//
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module assoc_cache_ctrl #(
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 6,
    parameter int WAYS    = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,

    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_hit,

    input  logic              flush,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,

    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int SETS  = 2**INDEX_W;
    localparam int LRU_W = $clog2(WAYS);
    localparam int TAG_W = ADDR_W - INDEX_W;

    localparam logic [LRU_W-1:0] c_oldest_age = LRU_W'(WAYS - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOOKUP    = 2'd1,
        ST_MISS_REQ  = 2'd2,
        ST_MISS_WAIT = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    //--------------------------------------------------------------------------
    // Storage
    //--------------------------------------------------------------------------
    logic [WAYS-1:0]   r_valid [SETS];
    logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
    logic [DATA_W-1:0] r_data  [SETS][WAYS];
    // Age 0 = most recently used, WAYS-1 = least recently used.
    logic [LRU_W-1:0]  r_age   [SETS][WAYS];

    logic [ADDR_W-1:0] r_req_addr;
    logic [LRU_W-1:0]  r_victim;
    logic [CNT_W-1:0]  r_hit_cnt;
    logic [CNT_W-1:0]  r_miss_cnt;

    //--------------------------------------------------------------------------
    // Request decode
    //--------------------------------------------------------------------------
    logic              w_accept;
    logic              w_flush_now;
    logic [INDEX_W-1:0] w_index;
    logic [TAG_W-1:0]  w_tag;

    // Flush wins over a simultaneous request, so a flush cycle never accepts.
    assign req_ready   = (r_state == ST_IDLE) & ~flush & ~rst;
    assign w_accept    = req_valid & req_ready;
    assign w_flush_now = (r_state == ST_IDLE) & flush & ~rst;

    // The set index and tag always come from the registered request address;
    // it is stable from LOOKUP until the fill completes.
    assign w_index = r_req_addr[INDEX_W-1:0];
    assign w_tag   = r_req_addr[ADDR_W-1:INDEX_W];

    //--------------------------------------------------------------------------
    // Tag compare across all ways of the indexed set
    //--------------------------------------------------------------------------
    logic [WAYS-1:0] w_way_hit;

    genvar g;
    generate
        for (g = 0; g < WAYS; g++) begin : g_way_cmp
            assign w_way_hit[g] = r_valid[w_index][g] & (r_tag[w_index][g] == w_tag);
        end
    endgenerate

    logic              w_hit;
    logic [LRU_W-1:0]  w_hit_way;
    logic [DATA_W-1:0] w_hit_data;

    // At most one way can match, so a simple priority scan is a clean encoder.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_way  = '0;
        w_hit_data = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (w_way_hit[i]) begin
                w_hit      = 1'b1;
                w_hit_way  = LRU_W'(i);
                w_hit_data = r_data[w_index][i];
            end
        end
    end

    //--------------------------------------------------------------------------
    // Victim selection: lowest-index invalid way, else the LRU way
    //--------------------------------------------------------------------------
    logic             w_any_invalid;
    logic [LRU_W-1:0] w_first_invalid;
    logic [LRU_W-1:0] w_oldest_way;
    logic [LRU_W-1:0] w_victim;

    always_comb begin
        w_any_invalid   = 1'b0;
        w_first_invalid = '0;
        w_oldest_way    = '0;
        // Scanning downward leaves the lowest invalid index as the final value.
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!r_valid[w_index][i]) begin
                w_any_invalid   = 1'b1;
                w_first_invalid = LRU_W'(i);
            end
        end
        // Ages form a permutation, so exactly one way carries the oldest age.
        for (int i = 0; i < WAYS; i++) begin
            if (r_age[w_index][i] == c_oldest_age) begin
                w_oldest_way = LRU_W'(i);
            end
        end
    end

    assign w_victim = w_any_invalid ? w_first_invalid : w_oldest_way;

    //--------------------------------------------------------------------------
    // Access events: a lookup hit, or a fill landing in the victim way
    //--------------------------------------------------------------------------
    logic             w_lookup_hit;
    logic             w_lookup_miss;
    logic             w_fill;
    logic             w_lru_en;
    logic [LRU_W-1:0] w_lru_way;
    logic [LRU_W-1:0] w_lru_old;

    assign w_lookup_hit  = (r_state == ST_LOOKUP) & w_hit & ~rst;
    assign w_lookup_miss = (r_state == ST_LOOKUP) & ~w_hit & ~rst;
    assign w_fill        = (r_state == ST_MISS_WAIT) & mem_resp_valid & ~rst;

    assign w_lru_en  = w_lookup_hit | w_fill;
    assign w_lru_way = (r_state == ST_LOOKUP) ? w_hit_way : r_victim;
    assign w_lru_old = r_age[w_index][w_lru_way];

    //--------------------------------------------------------------------------
    // FSM state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // FSM next state and outputs
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        resp_valid    = 1'b0;
        resp_data     = '0;
        resp_hit      = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;

        case (r_state)
            ST_IDLE: begin
                if (!flush && req_valid) begin
                    w_state_nxt = ST_LOOKUP;
                end
            end

            ST_LOOKUP: begin
                if (w_hit) begin
                    resp_valid  = 1'b1;
                    resp_data   = w_hit_data;
                    resp_hit    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_MISS_REQ;
                end
            end

            ST_MISS_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = r_req_addr;
                if (mem_req_ready) begin
                    w_state_nxt = ST_MISS_WAIT;
                end
            end

            ST_MISS_WAIT: begin
                // Fill data is forwarded straight to the requester in the
                // same cycle it is written into the array.
                if (mem_resp_valid) begin
                    resp_valid  = 1'b1;
                    resp_data   = mem_resp_data;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Reset abandons whatever is in flight, so nothing escapes during it.
        if (rst) begin
            resp_valid    = 1'b0;
            resp_data     = '0;
            resp_hit      = 1'b0;
            mem_req_valid = 1'b0;
            mem_req_addr  = '0;
        end
    end

    //--------------------------------------------------------------------------
    // Request address and victim registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_addr <= '0;
            r_victim   <= '0;
        end else begin
            if (w_accept) begin
                r_req_addr <= req_addr;
            end
            if (w_lookup_miss) begin
                r_victim <= w_victim;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Valid bits: cleared by reset and by flush, set by a completed fill
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || w_flush_now) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
            end
        end else if (w_fill) begin
            r_valid[w_index][r_victim] <= 1'b1;
        end
    end

    //--------------------------------------------------------------------------
    // Tag and data arrays: no reset, contents are meaningless while invalid
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_index][r_victim]  <= w_tag;
            r_data[w_index][r_victim] <= mem_resp_data;
        end
    end

    //--------------------------------------------------------------------------
    // True-LRU ages. The accessed way becomes youngest; only ways that were
    // younger than it age by one, which keeps each set a permutation.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_age[s][w] <= LRU_W'(w);
                end
            end
        end else if (w_lru_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (LRU_W'(w) == w_lru_way) begin
                    r_age[w_index][w] <= '0;
                end else if (r_age[w_index][w] < w_lru_old) begin
                    r_age[w_index][w] <= r_age[w_index][w] + LRU_W'(1);
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Saturating statistics counters; only reset clears them
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_lookup_hit && !(&r_hit_cnt)) begin
                r_hit_cnt <= r_hit_cnt + CNT_W'(1);
            end
            if (w_lookup_miss && !(&r_miss_cnt)) begin
                r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            end
        end
    end

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;

endmodule

`default_nettype wire

// File: tb/tb_assoc_cache_ctrl.sv
//==============================================================================
// Module      : tb_assoc_cache_ctrl
// Description : Directed bench for assoc_cache_ctrl. Stimulus pushes the
//               expected response of each read into a queue; a monitor pops
//               and compares whenever resp_valid is seen. CNT_W is 4 so that
//               counter saturation is reachable quickly.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_assoc_cache_ctrl;

    localparam int ADDR_W  = 15;
    localparam int DATA_W  = 32;
    localparam int INDEX_W = 6;
    localparam int WAYS    = 4;
    localparam int CNT_W   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_hit;
    logic              flush;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    always #5 clk = ~clk;

    assoc_cache_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .INDEX_W (INDEX_W),
        .WAYS    (WAYS),
        .CNT_W   (CNT_W)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .resp_hit       (resp_hit),
        .flush          (flush),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              hit;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   mem_hs = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Response monitor / scoreboard
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_req_valid === 1'b1 && mem_req_ready === 1'b1) begin
                mem_hs++;
            end
            if (resp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got data 0x%0h hit %0b, expected no response",
                             resp_data, resp_hit);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_data", 64'(resp_data), 64'(e.data));
                    check("resp_hit", 64'(resp_hit), 64'(e.hit));
                end
            end
        end
    end

    // All tasks start and end at posedge+1.
    task automatic do_reset();
        rst            = 1'b1;
        req_valid      = 1'b0;
        req_addr       = '0;
        flush          = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_data", 64'(resp_data), 64'd0);
        check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_mem_req_addr", 64'(mem_req_addr), 64'd0);
        check("rst_hit_count", 64'(hit_count), 64'd0);
        check("rst_miss_count", 64'(miss_count), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // One read. For a miss the task plays memory: optional backpressure of
    // bp cycles (with a spurious mem_resp_valid pulse), then data after delay.
    task automatic do_read(input logic [ADDR_W-1:0] addr, input logic exp_hit,
                           input logic [DATA_W-1:0] data, input int delay, input int bp);
        int   n;
        exp_t e;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("req_ready_before_req", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        e.data    = data;
        e.hit     = exp_hit;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (exp_hit) begin
            @(negedge clk);
            check("hit_latency_resp_valid", 64'(resp_valid), 64'd1);
            check("hit_no_mem_req", 64'(mem_req_valid), 64'd0);
            @(posedge clk);
            #1;
        end else begin
            n = 0;
            while (mem_req_valid !== 1'b1 && n < 10) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("miss_mem_req_valid", 64'(mem_req_valid), 64'd1);
            check("miss_mem_req_addr", 64'(mem_req_addr), 64'(addr));
            for (int i = 0; i < bp; i++) begin
                mem_resp_valid = (i == 2);
                mem_resp_data  = 32'h1111_1111;
                @(negedge clk);
                check("bp_mem_req_valid", 64'(mem_req_valid), 64'd1);
                check("bp_mem_req_addr", 64'(mem_req_addr), 64'(addr));
                check("bp_req_ready", 64'(req_ready), 64'd0);
                @(posedge clk);
                #1;
            end
            mem_resp_valid = 1'b0;
            mem_req_ready  = 1'b1;
            @(posedge clk);
            #1;
            mem_req_ready = 1'b0;
            for (int i = 0; i < delay; i++) begin
                @(posedge clk);
                #1;
            end
            mem_resp_valid = 1'b1;
            mem_resp_data  = data;
            @(posedge clk);
            #1;
            mem_resp_valid = 1'b0;
        end
    endtask

    initial begin : stim
        do_reset();

        // Cold miss then hit
        do_read(15'h0005, 1'b0, 32'hDEAD_BEEF, 3, 0);
        do_read(15'h0005, 1'b1, 32'hDEAD_BEEF, 0, 0);
        check("cold_fill_count", 64'(mem_hs), 64'd1);
        check("cold_hit_count", 64'(hit_count), 64'd1);
        check("cold_miss_count", 64'(miss_count), 64'd1);

        // LRU eviction in set 5
        do_reset();
        do_read(15'h0005, 1'b0, 32'd1, 0, 0);
        do_read(15'h0045, 1'b0, 32'd2, 1, 0);
        do_read(15'h0085, 1'b0, 32'd3, 0, 0);
        do_read(15'h00C5, 1'b0, 32'd4, 2, 0);
        do_read(15'h0005, 1'b1, 32'd1, 0, 0);
        do_read(15'h0105, 1'b0, 32'd5, 0, 0);  // evicts 0x0045
        do_read(15'h0045, 1'b0, 32'd6, 0, 0);  // evicts 0x0085
        do_read(15'h0005, 1'b1, 32'd1, 0, 0);
        do_read(15'h0105, 1'b1, 32'd5, 0, 0);
        do_read(15'h00C5, 1'b1, 32'd4, 0, 0);
        check("lru_hit_count", 64'(hit_count), 64'd4);
        check("lru_miss_count", 64'(miss_count), 64'd6);

        // Memory backpressure with a spurious fill strobe during MISS_REQ
        do_reset();
        do_read(15'h0123, 1'b0, 32'h0BAD_F00D, 2, 5);
        do_read(15'h0123, 1'b1, 32'h0BAD_F00D, 0, 0);
        check("bp_miss_count", 64'(miss_count), 64'd1);

        // Flush priority over a simultaneous request
        do_reset();
        do_read(15'h0005, 1'b0, 32'hCAFE_0001, 1, 0);
        do_read(15'h0005, 1'b1, 32'hCAFE_0001, 0, 0);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 15'h0005;
        @(negedge clk);
        check("flush_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        do_read(15'h0005, 1'b0, 32'hCAFE_0002, 1, 0);
        check("flush_hit_count", 64'(hit_count), 64'd1);
        check("flush_miss_count", 64'(miss_count), 64'd2);

        // Reset while waiting for fill data
        do_reset();
        req_valid = 1'b1;
        req_addr  = 15'h0007;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rmm_mem_req_valid", 64'(mem_req_valid), 64'd1);
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_req_ready = 1'b0;
        check("rmm_miss_before", 64'(miss_count), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst            = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hAAAA_5555;
        @(negedge clk);
        check("rmm_no_resp", 64'(resp_valid), 64'd0);
        check("rmm_req_ready", 64'(req_ready), 64'd1);
        check("rmm_hit_count", 64'(hit_count), 64'd0);
        check("rmm_miss_count", 64'(miss_count), 64'd0);
        @(posedge clk);
        #1;
        mem_resp_valid = 1'b0;
        do_read(15'h0007, 1'b0, 32'h0000_0077, 1, 0);
        check("rmm_miss_after", 64'(miss_count), 64'd1);

        // Counter saturation at 4'hF
        do_reset();
        do_read(15'h0010, 1'b0, 32'h5A5A_0010, 0, 0);
        for (int i = 0; i < 15; i++) begin
            do_read(15'h0010, 1'b1, 32'h5A5A_0010, 0, 0);
        end
        check("sat_hit_count_15", 64'(hit_count), 64'hF);
        for (int i = 0; i < 2; i++) begin
            do_read(15'h0010, 1'b1, 32'h5A5A_0010, 0, 0);
        end
        check("sat_hit_count_17", 64'(hit_count), 64'hF);
        check("sat_miss_count", 64'(miss_count), 64'd1);

        repeat (3) @(posedge clk);
        #1;
        check("pending_responses", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/assoc_cache_ctrl.md
Name: assoc_cache_ctrl

Overview:
- Parametrised N-way set-associative read cache controller with true-LRU replacement, flush, and a valid/ready miss-fill handshake to backing memory.
- Next generation of the direct-mapped tag/valid/data cache. Sits between the requester and backing memory.
- One-word lines. Storage is register arrays internal to the block.
- Adds hit/miss statistics counters.

Parameters:
- ADDR_W, 15, request/memory address width (word address)
- DATA_W, 32, data word width
- INDEX_W, 6, set index width; SETS = 2**INDEX_W
- WAYS, 4, associativity; power of 2, ≥2; LRU_W = log2(WAYS)
- CNT_W, 16, statistics counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  read request valid
- req_ready  out  1  controller can accept request
- req_addr  in  ADDR_W  request address; index = [INDEX_W-1:0], tag = [ADDR_W-1:INDEX_W]
- resp_valid  out  1  one-cycle response strobe
- resp_data  out  DATA_W  response data
- resp_hit  out  1  response was a hit (valid with resp_valid)
- flush  in  1  invalidate all lines
- mem_req_valid  out  1  fill request to memory
- mem_req_ready  in  1  memory accepts fill request
- mem_req_addr  out  ADDR_W  fill address
- mem_resp_valid  in  1  fill data valid
- mem_resp_data  in  DATA_W  fill data
- hit_count  out  CNT_W  saturating hit counter
- miss_count  out  CNT_W  saturating miss counter

Behaviour:
- Reset: rst is synchronous and active-high; clk is the clock.
  - State returns to IDLE.
  - All valid bits clear.
  - LRU age of way w in every set = w.
  - resp_valid, resp_hit, mem_req_valid, hit_count and miss_count all 0.
  - resp_data and mem_req_addr are 0.
  - Tag/data arrays are not cleared.
- req_ready = (state==IDLE) & ~flush & ~rst.
- The request is accepted on req_valid & req_ready. req_addr is registered and held internally until the response.
- FSM states: IDLE, LOOKUP, MISS_REQ, MISS_WAIT.
  - IDLE:
    - flush=1 clears every valid bit at this edge and stays in IDLE. Flush has priority; a simultaneous request is not accepted.
    - Otherwise an accepted request goes to LOOKUP.
  - LOOKUP:
    - Compare the tag against all ways of the indexed set. Hit = valid & tag match; at most one way may match.
    - On hit: resp_valid=1, resp_data = way data, resp_hit=1 this cycle (one cycle after accept). Update LRU, increment hit_count, go to IDLE.
    - On miss: select the victim. It is the lowest-index invalid way; if the set is full, it is the way with age == WAYS-1.
    - Register the victim, increment miss_count, go to MISS_REQ.
  - MISS_REQ:
    - mem_req_valid=1 with mem_req_addr = request address. Both are held stable until mem_req_ready.
    - On mem_req_valid & mem_req_ready, go to MISS_WAIT.
  - MISS_WAIT:
    - mem_req_valid=0. Wait any number of cycles for mem_resp_valid.
    - On mem_resp_valid: write data and tag to the victim way and set valid. Update LRU for the victim.
    - In the same cycle drive resp_valid=1, resp_data = mem_resp_data, resp_hit=0. Go to IDLE.
- mem_resp_valid outside MISS_WAIT is ignored.
- flush outside IDLE is ignored (no effect).
- LRU update on access to way w with old age a:
  - Age[w] becomes 0.
  - Every other way with age < a increments.
  - Ages in a set always remain a permutation of 0..WAYS-1.
- Counters saturate at all-ones, are cleared only by rst, and are not cleared by flush.
- resp_valid is a single-cycle pulse. There is no response backpressure.
- rst mid-miss abandons the fill. The line stays invalid, and the memory response arriving later is ignored.

Test Plan:
- Cold miss then hit:
  - After reset, read 0x0005.
  - Expect mem_req_valid with mem_req_addr=0x0005. Return 0xDEADBEEF 3 cycles later.
  - Expect resp_valid, resp_data=0xDEADBEEF, resp_hit=0.
  - Re-read 0x0005. Expect resp_valid one cycle after accept, resp_hit=1, no mem_req_valid.
  - Expect hit_count=1, miss_count=1.
- LRU eviction:
  - Fill 0x0005/0x0045/0x0085/0x00C5 with data 1/2/3/4 (all set 5).
  - Read 0x0005: expect hit, data 1.
  - Read 0x0105: expect miss, fill 5; this evicts the 0x0045 line.
  - Read 0x0045: expect miss.
  - Read 0x0005: expect hit, data 1.
- Memory backpressure:
  - Hold mem_req_ready=0 for 5 cycles during a miss on 0x0123.
  - Expect mem_req_valid=1 and mem_req_addr=0x0123 stable all 5 cycles, and req_ready=0 throughout.
  - A spurious mem_resp_valid during MISS_REQ must be ignored.
- Flush priority:
  - After 0x0005 is cached, assert flush=1 and req_valid=1 in the same IDLE cycle.
  - Expect req_ready=0 and no response.
  - Next read of 0x0005 misses; hit_count is unchanged.
- Reset mid-miss:
  - Read 0x0007. Assert rst for 1 cycle while in MISS_WAIT, then pulse mem_resp_valid with data 0xAAAA5555.
  - Expect no resp_valid, both counters 0, req_ready=1.
  - Read 0x0007 again: expect a miss.
- Counter saturation:
  - With CNT_W=4, perform 17 hits on one address.
  - Expect hit_count to hold at 0xF.
